mano_out_port: RTL

Device-side end of the Mano computer's output channel. The CPU executes OUT and writes AC into OUTR, and this block is the reader of that register. It drains OUTR onto a serial line as an 8N1 UART frame and manages the FGO ready flag that the CPU polls with SKO or takes as an interrupt. It sits beside the AC/bus datapath in `mano_all` and consumes the AC value and the OUT strobe from the control unit.

---
 rtl/mano_io_pkg.sv | 28 ++
 rtl/mano_bit_timer.sv | 55 +++++
 rtl/mano_out_port.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mano_io_pkg.sv
// -----------------------------------------------------------------------------
// mano_io_pkg
// Shared definitions for the Mano computer output channel:
//   - out_state_e      : serializer FSM states (IDLE -> START -> DATA -> STOP)
//   - DEF_CLKS_PER_BIT : default clock cycles per serial bit
//   - DEF_DATA_W       : default OUTR width (matches AC)
//   - FRAME_BITS       : bits per 8N1 frame (start + data + stop)
//   - frame_cycles()   : frame length in clock cycles for a given configuration
// -----------------------------------------------------------------------------
package mano_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } out_state_e;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_W       = 8;
  localparam int FRAME_BITS       = DEF_DATA_W + 2;

  // Number of cycles from the load edge to the edge that raises FGO.
  function automatic int frame_cycles(input int data_w, input int clks_per_bit);
    return (data_w + 2) * clks_per_bit;
  endfunction

endpackage

// File: rtl/mano_bit_timer.sv
// -----------------------------------------------------------------------------
// mano_bit_timer
// Bit-period cycle counter for the output serializer.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset (counter -> 0)
//   restart in  synchronous restart; counter returns to 0 on the next edge
//   en      in  count enable; while low the counter is held at 0
//   tick    out high on the last cycle of each bit period (combinational
//               decode of the counter register)
// -----------------------------------------------------------------------------
module mano_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = en && (cnt_q == LAST_CNT);

  // Next-count logic: restart and idle both park the counter at zero so a new
  // bit period always starts from a clean count.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (!en) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE_CNT;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mano_out_port.sv
// -----------------------------------------------------------------------------
// mano_out_port
// Device side of the Mano output channel. Captures AC into OUTR on an accepted
// OUT strobe and shifts it out as an 8N1 UART frame, managing the FGO ready
// flag and a sticky overrun flag.
// Ports:
//   CLK      in  system clock (rising edge)
//   RST_N    in  asynchronous active-low reset
//   OUT_LD   in  one-cycle OUT strobe from the control unit
//   OUT_DATA in  AC contents, captured when a load is accepted
//   IEN      in  interrupt enable
//   OUTR     out output register
//   FGO      out ready flag (1 = can accept a character)
//   IRQ      out IEN & FGO (combinational)
//   TXD      out serial line, idle high
//   BUSY     out high whenever the FSM is not IDLE
//   OVR      out sticky overrun flag, cleared only by reset
// -----------------------------------------------------------------------------
module mano_out_port
  import mano_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_W       = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              OUT_LD,
  input  logic [DATA_W-1:0] OUT_DATA,
  input  logic              IEN,
  output logic [DATA_W-1:0] OUTR,
  output logic              FGO,
  output logic              IRQ,
  output logic              TXD,
  output logic              BUSY,
  output logic              OVR
);

  localparam int IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  out_state_e        state_q, state_d;
  logic [DATA_W-1:0] outr_q, outr_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              fgo_q, fgo_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              ovr_q, ovr_d;

  logic              accept_s;
  logic              tick_s;
  logic              timer_en_s;
  logic [IDX_W-1:0]  idx_inc_s;

  assign timer_en_s = (state_q != IDLE);
  assign idx_inc_s  = bit_idx_q + ONE_IDX;

  mano_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (CLK),
    .rst_n   (RST_N),
    .restart (accept_s),
    .en      (timer_en_s),
    .tick    (tick_s)
  );

  // Next-state, OUTR/FGO/OVR update and registered-TXD lookahead. TXD is
  // computed for the state being entered so the line changes on the same
  // edge as the state register.
  always_comb begin
    state_d   = state_q;
    outr_d    = outr_q;
    bit_idx_d = bit_idx_q;
    fgo_d     = fgo_q;
    txd_d     = txd_q;
    ovr_d     = ovr_q;
    accept_s  = 1'b0;

    // Loads are accepted only when ready; anything else is an overrun,
    // including a strobe on the STOP-final cycle where FGO is still low.
    if (OUT_LD) begin
      if (fgo_q && (state_q == IDLE)) begin
        accept_s = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
    end

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (accept_s) begin
          outr_d    = OUT_DATA;
          fgo_d     = 1'b0;
          txd_d     = 1'b0;
          bit_idx_d = '0;
          state_d   = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          bit_idx_d = '0;
          txd_d     = outr_q[0];
          state_d   = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          if (bit_idx_q == LAST_IDX) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = idx_inc_s;
            txd_d     = outr_q[idx_inc_s];
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (tick_s) begin
          fgo_d   = 1'b1;
          txd_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        fgo_d   = 1'b1;
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      outr_q    <= '0;
      bit_idx_q <= '0;
      fgo_q     <= 1'b1;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      outr_q    <= outr_d;
      bit_idx_q <= bit_idx_d;
      fgo_q     <= fgo_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
    end
  end

  assign OUTR = outr_q;
  assign FGO  = fgo_q;
  assign TXD  = txd_q;
  assign BUSY = busy_q;
  assign OVR  = ovr_q;
  assign IRQ  = IEN & fgo_q;

endmodule
